// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: captures decoded control and operands each cycle,
// with a hazard stall (hold), a branch flush (bubble), and debug counters.
module id_ex_stage_reg #(
  parameter int WORD  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             freeze,
  input  logic             flush,
  input  logic             valid_in,
  input  logic [3:0]       exe_command_in,
  input  logic             mem_read_in,
  input  logic             mem_write_in,
  input  logic             wb_enable_in,
  input  logic             is_immediate_in,
  input  logic             b_in,
  input  logic             s_in,
  input  logic [WORD-1:0]  pc_in,
  input  logic [WORD-1:0]  val_rn_in,
  input  logic [WORD-1:0]  val_rm_in,
  input  logic [11:0]      shift_operand_in,
  input  logic [23:0]      imm24_in,
  input  logic [3:0]       dest_in,
  input  logic [3:0]       src1_in,
  input  logic [3:0]       src2_in,
  input  logic [3:0]       status_in,
  output logic             valid_out,
  output logic [3:0]       exe_command_out,
  output logic             mem_read_out,
  output logic             mem_write_out,
  output logic             wb_enable_out,
  output logic             is_immediate_out,
  output logic             b_out,
  output logic             s_out,
  output logic [WORD-1:0]  pc_out,
  output logic [WORD-1:0]  val_rn_out,
  output logic [WORD-1:0]  val_rm_out,
  output logic [11:0]      shift_operand_out,
  output logic [23:0]      imm24_out,
  output logic [3:0]       dest_out,
  output logic [3:0]       src1_out,
  output logic [3:0]       src2_out,
  output logic [3:0]       status_out,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {ST_RESET, ST_LOAD, ST_HOLD, ST_BUBBLE} sel_e;

  typedef struct packed {
    logic            valid;
    logic [3:0]      exe_command;
    logic            mem_read;
    logic            mem_write;
    logic            wb_enable;
    logic            is_immediate;
    logic            b;
    logic            s;
    logic [WORD-1:0] pc;
    logic [WORD-1:0] val_rn;
    logic [WORD-1:0] val_rm;
    logic [11:0]     shift_operand;
    logic [23:0]     imm24;
    logic [3:0]      dest;
    logic [3:0]      src1;
    logic [3:0]      src2;
    logic [3:0]      status;
  } stage_t;

  stage_t     r_stage;
  stage_t     w_capture;
  sel_e       w_sel;
  logic [CNT_W-1:0] r_bubble_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  // Priority: reset > flush > freeze > load; no memory of the previous choice.
  always_comb begin
    // NOTE: default first so every path assigns w_sel and no latch is inferred.
    w_sel = ST_LOAD;
    if (!rst_n)      w_sel = ST_RESET;
    else if (flush)  w_sel = ST_BUBBLE;
    else if (freeze) w_sel = ST_HOLD;
  end

  // Side-effecting control bits are gated by valid_in so a non-instruction
  // can never write memory, the register file, flags or the PC.
  always_comb begin
    w_capture.valid         = valid_in;
    w_capture.exe_command   = exe_command_in;
    w_capture.mem_read      = mem_read_in  & valid_in;
    w_capture.mem_write     = mem_write_in & valid_in;
    w_capture.wb_enable     = wb_enable_in & valid_in;
    w_capture.is_immediate  = is_immediate_in;
    w_capture.b             = b_in & valid_in;
    w_capture.s             = s_in & valid_in;
    w_capture.pc            = pc_in;
    w_capture.val_rn        = val_rn_in;
    w_capture.val_rm        = val_rm_in;
    w_capture.shift_operand = shift_operand_in;
    w_capture.imm24         = imm24_in;
    w_capture.dest          = dest_in;
    w_capture.src1          = src1_in;
    w_capture.src2          = src2_in;
    w_capture.status        = status_in;
  end

  // NOTE: non-blocking assignments for all state so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    case (w_sel)
      ST_RESET: begin
        r_stage      <= '0;
        r_bubble_cnt <= '0;
        r_stall_cnt  <= '0;
      end
      ST_BUBBLE: begin
        r_stage <= '0;
        if (r_bubble_cnt != '1) r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      end
      ST_HOLD: begin
        if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      default: r_stage <= w_capture;
    endcase
  end

  assign valid_out         = r_stage.valid;
  assign exe_command_out   = r_stage.exe_command;
  assign mem_read_out      = r_stage.mem_read;
  assign mem_write_out     = r_stage.mem_write;
  assign wb_enable_out     = r_stage.wb_enable;
  assign is_immediate_out  = r_stage.is_immediate;
  assign b_out             = r_stage.b;
  assign s_out             = r_stage.s;
  assign pc_out            = r_stage.pc;
  assign val_rn_out        = r_stage.val_rn;
  assign val_rm_out        = r_stage.val_rm;
  assign shift_operand_out = r_stage.shift_operand;
  assign imm24_out         = r_stage.imm24;
  assign dest_out          = r_stage.dest;
  assign src1_out          = r_stage.src1;
  assign src2_out          = r_stage.src2;
  assign status_out        = r_stage.status;
  assign bubble_cnt        = r_bubble_cnt;
  assign stall_cnt         = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg with 4-bit counters so saturation is reachable.
module tb_id_ex_stage_reg;

  localparam int WORD  = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n, freeze, flush, valid_in;
  logic [3:0]       exe_command_in;
  logic             mem_read_in, mem_write_in, wb_enable_in, is_immediate_in, b_in, s_in;
  logic [WORD-1:0]  pc_in, val_rn_in, val_rm_in;
  logic [11:0]      shift_operand_in;
  logic [23:0]      imm24_in;
  logic [3:0]       dest_in, src1_in, src2_in, status_in;
  logic             valid_out;
  logic [3:0]       exe_command_out;
  logic             mem_read_out, mem_write_out, wb_enable_out, is_immediate_out, b_out, s_out;
  logic [WORD-1:0]  pc_out, val_rn_out, val_rm_out;
  logic [11:0]      shift_operand_out;
  logic [23:0]      imm24_out;
  logic [3:0]       dest_out, src1_out, src2_out, status_out;
  logic [CNT_W-1:0] bubble_cnt, stall_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_ex_stage_reg #(.WORD(WORD), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush), .valid_in(valid_in),
    .exe_command_in(exe_command_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .wb_enable_in(wb_enable_in), .is_immediate_in(is_immediate_in), .b_in(b_in), .s_in(s_in),
    .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
    .shift_operand_in(shift_operand_in), .imm24_in(imm24_in), .dest_in(dest_in),
    .src1_in(src1_in), .src2_in(src2_in), .status_in(status_in),
    .valid_out(valid_out), .exe_command_out(exe_command_out), .mem_read_out(mem_read_out),
    .mem_write_out(mem_write_out), .wb_enable_out(wb_enable_out),
    .is_immediate_out(is_immediate_out), .b_out(b_out), .s_out(s_out),
    .pc_out(pc_out), .val_rn_out(val_rn_out), .val_rm_out(val_rm_out),
    .shift_operand_out(shift_operand_out), .imm24_out(imm24_out), .dest_out(dest_out),
    .src1_out(src1_out), .src2_out(src2_out), .status_out(status_out),
    .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit before sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctrl(input logic v, input logic [3:0] cmd, input logic mr, input logic mw,
                          input logic wb, input logic b, input logic s);
    valid_in = v; exe_command_in = cmd; mem_read_in = mr; mem_write_in = mw;
    wb_enable_in = wb; b_in = b; s_in = s;
  endtask

  initial begin
    // Reset with every input nonzero, including flush and freeze.
    rst_n = 1'b0; freeze = 1'b1; flush = 1'b1;
    set_ctrl(1'b1, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    is_immediate_in = 1'b1;
    pc_in = 32'hFFFF_FFFF; val_rn_in = 32'hAAAA_AAAA; val_rm_in = 32'h5555_5555;
    shift_operand_in = 12'hFFF; imm24_in = 24'hFFFFFF; dest_in = 4'hF;
    src1_in = 4'hE; src2_in = 4'hD; status_in = 4'hF;
    tick();
    tick();
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_cmd", 32'(exe_command_out), 32'd0);
    check("rst_ctrl", 32'({mem_read_out, mem_write_out, wb_enable_out, is_immediate_out, b_out, s_out}), 32'd0);
    check("rst_pc", pc_out, 32'd0);
    check("rst_rn", val_rn_out, 32'd0);
    check("rst_misc", 32'({shift_operand_out, dest_out, src1_out, src2_out, status_out}), 32'd0);
    check("rst_imm", 32'(imm24_out), 32'd0);
    check("rst_cnts", 32'({bubble_cnt, stall_cnt}), 32'd0);

    // ADD r3, r1, r2 with Rn=5, Rm=7.
    rst_n = 1'b1; freeze = 1'b0; flush = 1'b0;
    set_ctrl(1'b1, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    is_immediate_in = 1'b0;
    pc_in = 32'h0000_0010; val_rn_in = 32'h5; val_rm_in = 32'h7;
    shift_operand_in = 12'h002; imm24_in = 24'h0; dest_in = 4'd3;
    src1_in = 4'd1; src2_in = 4'd2; status_in = 4'b0010;
    tick();
    check("add_cmd", 32'(exe_command_out), 32'h2);
    check("add_wb", 32'(wb_enable_out), 32'd1);
    check("add_rn", val_rn_out, 32'h5);
    check("add_rm", val_rm_out, 32'h7);
    check("add_dest", 32'(dest_out), 32'd3);
    check("add_valid", 32'(valid_out), 32'd1);
    check("add_pc", pc_out, 32'h10);
    check("add_srcs", 32'({src1_out, src2_out, status_out}), 32'h122);
    check("add_shop", 32'(shift_operand_out), 32'h002);

    // LDR r4, [r1, #0x100].
    set_ctrl(1'b1, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    is_immediate_in = 1'b1; val_rn_in = 32'h100; dest_in = 4'd4; pc_in = 32'h14;
    tick();
    check("ldr_mr", 32'(mem_read_out), 32'd1);
    check("ldr_dest", 32'(dest_out), 32'd4);

    // Freeze for 3 cycles while the inputs present an STR.
    freeze = 1'b1;
    set_ctrl(1'b1, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    dest_in = 4'd5; val_rn_in = 32'h200; pc_in = 32'h18;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("frz_mr", 32'(mem_read_out), 32'd1);
      check("frz_mw", 32'(mem_write_out), 32'd0);
      check("frz_dest", 32'(dest_out), 32'd4);
      check("frz_rn", val_rn_out, 32'h100);
      check("frz_stall", 32'(stall_cnt), 32'(k));
    end
    freeze = 1'b0;
    tick();
    check("str_mw", 32'(mem_write_out), 32'd1);
    check("str_mr", 32'(mem_read_out), 32'd0);
    check("str_dest", 32'(dest_out), 32'd5);
    check("str_stall", 32'(stall_cnt), 32'd3);

    // B with offset 0x123456, then flush and freeze together.
    set_ctrl(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    imm24_in = 24'h123456; pc_in = 32'h1C;
    tick();
    check("b_b", 32'(b_out), 32'd1);
    check("b_imm", 32'(imm24_out), 32'h123456);
    flush = 1'b1; freeze = 1'b1;
    tick();
    check("fl_ctrl", 32'({mem_read_out, mem_write_out, wb_enable_out, is_immediate_out, b_out, s_out}), 32'd0);
    check("fl_valid", 32'(valid_out), 32'd0);
    check("fl_imm", 32'(imm24_out), 32'd0);
    check("fl_pc", pc_out, 32'd0);
    check("fl_bubble", 32'(bubble_cnt), 32'd1);
    check("fl_stall", 32'(stall_cnt), 32'd3);

    // Invalid slot carrying write-enables: side effects masked, data kept.
    flush = 1'b0; freeze = 1'b0;
    set_ctrl(1'b0, 4'h4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    val_rn_in = 32'h9;
    tick();
    check("msk_wb", 32'(wb_enable_out), 32'd0);
    check("msk_mw", 32'(mem_write_out), 32'd0);
    check("msk_mr_b_s", 32'({mem_read_out, b_out, s_out}), 32'd0);
    check("msk_valid", 32'(valid_out), 32'd0);
    check("msk_cmd", 32'(exe_command_out), 32'h4);
    check("msk_rn", val_rn_out, 32'h9);

    // Freeze on an empty register still holds and counts.
    freeze = 1'b1;
    set_ctrl(1'b1, 4'h1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    val_rn_in = 32'h77;
    tick();
    check("efrz_stall", 32'(stall_cnt), 32'd4);
    check("efrz_valid", 32'(valid_out), 32'd0);
    check("efrz_rn", val_rn_out, 32'h9);

    // 20 more stall cycles: 4 + 20 saturates at 15.
    for (int k = 0; k < 20; k++) tick();
    check("sat_stall", 32'(stall_cnt), 32'hF);
    check("sat_bubble", 32'(bubble_cnt), 32'd1);
    check("sat_rn", val_rn_out, 32'h9);

    // Reset mid-stall drops the held contents and clears the counters.
    rst_n = 1'b0;
    tick();
    check("rst2_stall", 32'(stall_cnt), 32'd0);
    check("rst2_bubble", 32'(bubble_cnt), 32'd0);
    check("rst2_rn", val_rn_out, 32'd0);
    check("rst2_cmd", 32'(exe_command_out), 32'd0);

    // Release: next edge loads the presented instruction.
    rst_n = 1'b1; freeze = 1'b0;
    tick();
    check("rel_valid", 32'(valid_out), 32'd1);
    check("rel_rn", val_rn_out, 32'h77);
    check("rel_wb", 32'(wb_enable_out), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- Pipeline register between the instruction-decode stage (control unit, register file, operand fetch) and the execute stage of the 5-stage ARM-subset core.
- Captures decoded control bits and operands on every clock.
- Supports a hazard stall (freeze), a branch flush (bubble insertion) and a valid tag.
- Counts inserted bubbles and stalls for debug.

Parameters:
- WORD, 32, data path width (PC, Rn value, Rm value).
- CNT_W, 16, width of the stall and bubble counters.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- freeze  in  1  hazard stall from the hazard unit; hold all contents.
- flush  in  1  branch-taken flush; load a bubble.
- valid_in  in  1  ID stage holds a real instruction.
- exe_command_in  in  4  ALU command from the control unit.
- mem_read_in, mem_write_in, wb_enable_in, is_immediate_in, b_in, s_in  in  1 each  control bits.
- pc_in  in  WORD  PC+4 of the instruction.
- val_rn_in, val_rm_in  in  WORD  register operands.
- shift_operand_in  in  12  instruction bits [11:0].
- imm24_in  in  24  branch offset.
- dest_in  in  4  Rd.
- src1_in, src2_in  in  4  source register numbers, for forwarding.
- status_in  in  4  NZCV from the status register; C is needed by ADC/SBC.
- *_out  out  same widths  registered copy of every *_in above, plus valid_out.
- bubble_cnt  out  CNT_W  number of cycles a flush bubble was loaded.
- stall_cnt  out  CNT_W  number of cycles freeze held the register.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - Every *_out, valid_out and both counters go to 0.
  - Reset takes effect regardless of flush and freeze.
  - Reset asserted mid-stall drops the held instruction.
- Priority per edge: reset > flush > freeze > load.
- Load (rst_n=1, flush=0, freeze=0):
  - All outputs take their inputs.
  - Latency is exactly 1 cycle.
- Flush (flush=1):
  - Loads a bubble: exe_command=0 (NOP), all control bits 0, valid_out=0, all data fields 0.
  - bubble_cnt increments.
  - Flush wins over a simultaneous freeze: the branch kills the stalled instruction. In that case stall_cnt does not increment.
- Freeze (freeze=1, flush=0):
  - All outputs hold their previous value.
  - stall_cnt increments.
  - Freeze on an empty (valid_out=0) register still holds and still counts.
- Bubble guarantee: with valid_out=0, the outputs mem_read_out, mem_write_out, wb_enable_out, b_out and s_out are always 0. This holds even if valid_in=0 arrives together with nonzero control bits on a load: control outputs are ANDed with valid_in at capture.
- Counters saturate at all-ones and never wrap.
- Purely registered outputs; no combinational path from any input to any output.
- No internal FSM beyond the hold/load/bubble selection. Each cycle is one of four states {RESET, LOAD, HOLD, BUBBLE}, selected by the priority above. The selection is recomputed every cycle with no memory of the previous state.

Test Plan:
- Reset: drive all inputs nonzero with rst_n=0 for 2 cycles -> all outputs 0, counters 0. Release -> the next edge loads the inputs.
- Load: ADD (exe_command_in=4'b0010, wb_enable_in=1, val_rn_in=32'h5, val_rm_in=32'h7, dest_in=4'd3, valid_in=1) -> one cycle later the outputs match exactly, valid_out=1.
- Freeze: load an LDR (mem_read_in=1, exe_command_in=4'b0010). Hold freeze=1 for 3 cycles while the inputs change to an STR -> outputs remain the LDR for all 3 cycles, stall_cnt=3. Release -> the STR loads.
- Flush vs. freeze: with B (b_in=1) loaded, assert flush=1 and freeze=1 together -> next cycle all control outputs 0, valid_out=0, bubble_cnt=1, stall_cnt unchanged.
- Masking: valid_in=0 with wb_enable_in=1, mem_write_in=1 -> wb_enable_out=0, mem_write_out=0, valid_out=0.
- Saturation (CNT_W=4): hold freeze for 20 cycles -> stall_cnt stops at 4'hF. Reset -> stall_cnt=0.
